mem_ctrl: RTL and testbench

- Single owner of the byte-wide RAM port; arbitrates between instruction fetch (icache miss, 32-bit word) and the load/store buffer (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Sequences multi-byte accesses one byte per cycle, little-endian; returns load data tagged with the LSB slot id.
- Sits between the LSB/icache and the top-level RAM/IO bus.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_ctrl_load_extend.sv | 20 ++
 rtl/mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: funct3 codes,
// FSM encoding, IO window default and the per-access byte count.
package mem_ctrl_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
   typedef enum logic {GNT_LSB, GNT_IF} grant_t;

   // Width code lives in funct3[1:0] for both loads and stores.
   function automatic logic [2:0] byte_cnt(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   byte_cnt = 3'd1;
         2'b01:   byte_cnt = 3'd2;
         default: byte_cnt = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_load_extend.sv
// Assembles little-endian load bytes and applies sign/zero extension by funct3.
module mem_load_extend
   import mem_ctrl_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  funct3,
   output logic [31:0] val
);

   always_comb begin
      case (funct3)
         LB:      val = {{24{raw[7]}}, raw[7:0]};
         LH:      val = {{16{raw[15]}}, raw[15:0]};
         LBU:     val = {24'h0, raw[7:0]};
         LHU:     val = {16'h0, raw[15:0]};
         default: val = raw;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port owner: arbitrates icache fetch vs. load/store buffer and
// serialises accesses one byte per cycle. Optional macro: IO_BUFFER_STALL_EN.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter int                 LSB_ID_W = 3,
   parameter logic [ADDR_W-1:0]  IO_BASE  = ADDR_W'(IO_BASE_DEF)
) (
   input  logic                 clk,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 flush,
   input  logic                 if_req_en,
   input  logic [ADDR_W-1:0]    if_addr,
   output logic                 if_done,
   output logic [31:0]          if_data,
   input  logic                 lsb2mem_en,
   input  logic                 lsb2mem_store_load,
   input  logic [ADDR_W-1:0]    lsb2mem_addr,
   input  logic [2:0]           lsb2mem_type,
   input  logic [31:0]          lsb2mem_val,
   input  logic [LSB_ID_W-1:0]  lsb2mem_load_id,
   output logic                 mem_busy,
   output logic                 mem2lsb_load_en,
   output logic [LSB_ID_W-1:0]  mem2lsb_load_id,
   output logic [31:0]          mem2lsb_load_val,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [ADDR_W-1:0]    mem_a,
   output logic                 mem_wr,
   input  logic                 io_buffer_full
);

   state_t                state, state_nxt;
   grant_t                last_grant;

   logic                  pend_valid, pend_store;
   logic [2:0]            pend_f3;
   logic [ADDR_W-1:0]     pend_addr;
   logic [31:0]           pend_val;
   logic [LSB_ID_W-1:0]   pend_id;

   logic [2:0]            cur_f3;
   logic [ADDR_W-1:0]     cur_addr;
   logic [31:0]           cur_val;
   logic [LSB_ID_W-1:0]   cur_id;
   logic [2:0]            cnt;
   logic [3:0][7:0]       rd_buf;

   logic [2:0]            n;
   logic                  rd_state, pend_eff, want_if, grant_lsb, grant_if;
   logic                  io_stall, done_cyc;

   assign n        = byte_cnt(cur_f3);
   assign rd_state = (state == FETCH) || (state == LOAD);

   // A flush kills a pending load in the same cycle, so it must not win arbitration.
   assign pend_eff  = pend_valid && !(flush && !pend_store);
   assign want_if   = if_req_en && !flush;
   assign grant_lsb = (state == IDLE) && pend_eff && (!want_if || last_grant == GNT_IF);
   assign grant_if  = (state == IDLE) && want_if && (!pend_eff || last_grant == GNT_LSB);

`ifdef IO_BUFFER_STALL_EN
   assign io_stall = (state == STORE) && (cur_addr >= IO_BASE) && io_buffer_full;
`else
   logic unused_io;
   assign io_stall  = 1'b0;
   assign unused_io = io_buffer_full & (cur_addr >= IO_BASE);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_lsb)     state_nxt = pend_store ? STORE : LOAD;
            else if (grant_if) state_nxt = FETCH;
         end
         FETCH, LOAD: if (flush || cnt == n + 3'd1) state_nxt = IDLE;
         STORE:       if (!io_stall && cnt == n - 3'd1) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_a    = '0;
      mem_dout = 8'h00;
      mem_wr   = 1'b0;
      if ((rd_state && cnt < n) || state == STORE)
         mem_a = cur_addr + ADDR_W'(cnt);
      if (state == STORE) begin
         mem_dout = cur_val[{cnt[1:0], 3'b000} +: 8];
         mem_wr   = rdy_in && !io_stall;
      end
   end

   // Done is combinational so a flush arriving in the done cycle can veto it.
   assign done_cyc        = rdy_in && !flush && (cnt == n + 3'd1);
   assign if_done         = (state == FETCH) && done_cyc;
   assign mem2lsb_load_en = (state == LOAD) && done_cyc;
   assign if_data         = rd_buf;
   assign mem2lsb_load_id = cur_id;
   assign mem_busy        = (state != IDLE) || pend_valid;

   mem_load_extend u_ext (
      .raw    (rd_buf),
      .funct3 (cur_f3),
      .val    (mem2lsb_load_val)
   );

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         last_grant <= GNT_LSB;
         pend_valid <= 1'b0;
         pend_store <= 1'b0;
         pend_f3    <= 3'd0;
         pend_addr  <= '0;
         pend_val   <= 32'h0;
         pend_id    <= '0;
         cur_f3     <= 3'd0;
         cur_addr   <= '0;
         cur_val    <= 32'h0;
         cur_id     <= '0;
         cnt        <= 3'd0;
         rd_buf     <= '0;
      end else if (rdy_in) begin
         state <= state_nxt;

         if (lsb2mem_en && !(flush && !lsb2mem_store_load)) begin
            pend_valid <= 1'b1;
            pend_store <= lsb2mem_store_load;
            pend_f3    <= lsb2mem_type;
            pend_addr  <= lsb2mem_addr;
            pend_val   <= lsb2mem_val;
            pend_id    <= lsb2mem_load_id;
         end else if (grant_lsb || (flush && !pend_store)) begin
            pend_valid <= 1'b0;
         end

         if (grant_lsb) begin
            last_grant <= GNT_LSB;
            cur_f3     <= pend_f3;
            cur_addr   <= pend_addr;
            cur_val    <= pend_val;
            cur_id     <= pend_id;
            cnt        <= 3'd0;
         end else if (grant_if) begin
            last_grant <= GNT_IF;
            cur_f3     <= LW;
            cur_addr   <= if_addr;
            cnt        <= 3'd0;
         end else if (state != IDLE) begin
            if (!io_stall) cnt <= cnt + 3'd1;
            // RAM returns byte k one cycle after its address, i.e. while cnt = k+1.
            if (rd_state && cnt != 3'd0 && cnt <= n)
               rd_buf[cnt[1:0] - 2'd1] <= mem_din;
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, write log, hand-computed expectations.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in, flush, if_req_en;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        lsb2mem_en, lsb2mem_store_load;
   logic [31:0] lsb2mem_addr;
   logic [2:0]  lsb2mem_type;
   logic [31:0] lsb2mem_val;
   logic [2:0]  lsb2mem_load_id;
   logic        mem_busy, mem2lsb_load_en;
   logic [2:0]  mem2lsb_load_id;
   logic [31:0] mem2lsb_load_val;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;

   int vecs = 0;
   int errs = 0;

   logic [7:0]  ram [logic [31:0]];
   logic [39:0] wq [$];

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .if_req_en(if_req_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb2mem_en(lsb2mem_en), .lsb2mem_store_load(lsb2mem_store_load),
      .lsb2mem_addr(lsb2mem_addr), .lsb2mem_type(lsb2mem_type),
      .lsb2mem_val(lsb2mem_val), .lsb2mem_load_id(lsb2mem_load_id),
      .mem_busy(mem_busy), .mem2lsb_load_en(mem2lsb_load_en),
      .mem2lsb_load_id(mem2lsb_load_id), .mem2lsb_load_val(mem2lsb_load_val),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   // RAM: read data one cycle after address; writes also logged for checking.
   always @(posedge clk) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      if (mem_wr) begin
         wq.push_back({mem_a, mem_dout});
         ram[mem_a] = mem_dout;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lsb_req(input logic st, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] v, input logic [2:0] id);
      lsb2mem_en = 1'b1; lsb2mem_store_load = st; lsb2mem_addr = a;
      lsb2mem_type = f3; lsb2mem_val = v; lsb2mem_load_id = id;
      step();
      lsb2mem_en = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!(if_done || mem2lsb_load_en) && cyc < budget);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int          cyc;
      int          seen;
      logic [31:0] sw_val;

      rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; if_req_en = 1'b0; if_addr = '0;
      lsb2mem_en = 1'b0; lsb2mem_store_load = 1'b0; lsb2mem_addr = '0;
      lsb2mem_type = 3'd0; lsb2mem_val = '0; lsb2mem_load_id = '0; io_buffer_full = 1'b0;
      ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
      ram[32'h20] = 8'h80;
      ram[32'h50] = 8'h01; ram[32'h51] = 8'h02; ram[32'h52] = 8'h03; ram[32'h53] = 8'h04;
      step(); step();
      chk("rst_busy", {31'b0, mem_busy}, 32'd0);
      chk("rst_wr", {31'b0, mem_wr}, 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_done", {30'b0, if_done, mem2lsb_load_en}, 32'd0);
      rst_in = 1'b1;
      step();

      // Fetch: four consecutive byte addresses, done five cycles after entry.
      if_addr = 32'h1000; if_req_en = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("fetch_a", mem_a, 32'h1000 + k);
         chk("fetch_wr", {31'b0, mem_wr}, 32'd0);
         step();
      end
      chk("fetch_early", {31'b0, if_done}, 32'd0);
      step();
      chk("fetch_done", {31'b0, if_done}, 32'd1);
      chk("fetch_data", if_data, 32'h0000_0513);
      if_req_en = 1'b0;
      step();
      chk("fetch_idle", {31'b0, mem_busy}, 32'd0);

      // LB / LBU extension.
      lsb_req(1'b0, 32'h20, LB, '0, 3'd5);
      chk("lb_busy", {31'b0, mem_busy}, 32'd1);
      wait_done(10, cyc);
      chk("lb_lat", cyc, 32'd3);
      chk("lb_en", {31'b0, mem2lsb_load_en}, 32'd1);
      chk("lb_val", mem2lsb_load_val, 32'hFFFF_FF80);
      chk("lb_id", {29'b0, mem2lsb_load_id}, 32'd5);
      step();
      lsb_req(1'b0, 32'h20, LBU, '0, 3'd2);
      wait_done(10, cyc);
      chk("lbu_val", mem2lsb_load_val, 32'h0000_0080);
      chk("lbu_id", {29'b0, mem2lsb_load_id}, 32'd2);
      step();

      // SH: two write cycles, busy throughout, then idle; read back as LH.
      lsb_req(1'b1, 32'h40, SH, 32'h1234_ABCD, 3'd0);
      chk("sh_busy0", {31'b0, mem_busy}, 32'd1);
      step();
      chk("sh_a0", mem_a, 32'h40);
      chk("sh_d0", {24'b0, mem_dout}, 32'hCD);
      chk("sh_wr0", {30'b0, mem_wr, mem_busy}, 32'd3);
      step();
      chk("sh_a1", mem_a, 32'h41);
      chk("sh_d1", {24'b0, mem_dout}, 32'hAB);
      chk("sh_wr1", {30'b0, mem_wr, mem_busy}, 32'd3);
      step();
      chk("sh_end", {30'b0, mem_wr, mem_busy}, 32'd0);
      lsb_req(1'b0, 32'h40, LH, '0, 3'd3);
      wait_done(10, cyc);
      chk("lh_val", mem2lsb_load_val, 32'hFFFF_ABCD);
      step();

      // Arbitration: fetch first so last_grant=FETCH, then contend on every done.
      if_addr = 32'h1000; if_req_en = 1'b1;
      wait_done(10, cyc);
      chk("arb_pre", {31'b0, if_done}, 32'd1);
      for (int r = 0; r < 8; r++) begin
         lsb_req(1'b0, 32'h20, LB, '0, 3'(r));
         wait_done(12, cyc);
         if (r % 2 == 0) begin
            chk("arb_lsb", {30'b0, mem2lsb_load_en, if_done}, 32'd2);
            chk("arb_id", {29'b0, mem2lsb_load_id}, 32'(r));
         end else begin
            chk("arb_if", {30'b0, mem2lsb_load_en, if_done}, 32'd1);
            chk("arb_data", if_data, 32'h0000_0513);
         end
      end
      if_req_en = 1'b0;
      wait_done(12, cyc);
      chk("arb_tail", {30'b0, mem2lsb_load_en, if_done}, 32'd2);
      chk("arb_tail_id", {29'b0, mem2lsb_load_id}, 32'd7);
      step();

      // Flush during LW byte 2: no completion.
      lsb_req(1'b0, 32'h50, LW, '0, 3'd1);
      step(); step(); step();
      chk("flw_a", mem_a, 32'h52);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flw_idle", {31'b0, mem_busy}, 32'd0);
      seen = 0;
      repeat (8) begin step(); if (mem2lsb_load_en) seen++; end
      chk("flw_nodone", seen, 32'd0);

      // Flush coincident with the done cycle suppresses the pulse.
      lsb_req(1'b0, 32'h20, LB, '0, 3'd4);
      step(); step(); step();
      flush = 1'b1;
      #1;
      chk("fdone_sup", {31'b0, mem2lsb_load_en}, 32'd0);
      step();
      flush = 1'b0;
      chk("fdone_idle", {31'b0, mem_busy}, 32'd0);

      // Flush drops an in-flight fetch and a pending load.
      if_addr = 32'h1000; if_req_en = 1'b1;
      step();
      lsb_req(1'b0, 32'h20, LB, '0, 3'd6);
      flush = 1'b1; if_req_en = 1'b0;
      step();
      flush = 1'b0;
      chk("fpend_idle", {31'b0, mem_busy}, 32'd0);
      seen = 0;
      repeat (8) begin step(); if (mem2lsb_load_en || if_done) seen++; end
      chk("fpend_nodone", seen, 32'd0);

      // Flush during SW: all four writes still issue.
      wq.delete();
      sw_val = 32'hDEAD_BEEF;
      lsb_req(1'b1, 32'h60, SW, sw_val, 3'd0);
      step();
      flush = 1'b1;
      step(); step();
      flush = 1'b0;
      repeat (6) step();
      chk("fsw_cnt", wq.size(), 32'd4);
      for (int k = 0; k < 4 && k < wq.size(); k++) begin
         chk("fsw_a", wq[k][39:8], 32'h60 + k);
         chk("fsw_d", {24'b0, wq[k][7:0]}, 32'(sw_val >> (8 * k)) & 32'hFF);
      end

      // rdy_in low freezes the store mid-word.
      lsb_req(1'b1, 32'h70, SW, 32'h4433_2211, 3'd0);
      step();
      chk("rdy_a0", mem_a, 32'h70);
      step();
      rdy_in = 1'b0;
      #1;
      chk("rdy_wr0", {31'b0, mem_wr}, 32'd0);
      step();
      chk("rdy_hold_a", mem_a, 32'h71);
      chk("rdy_hold_wr", {31'b0, mem_wr}, 32'd0);
      rdy_in = 1'b1;
      #1;
      chk("rdy_resume", {23'b0, mem_wr, mem_dout}, 32'h122);
      repeat (4) step();
      chk("rdy_ram", {ram[32'h73], ram[32'h72], ram[32'h71], ram[32'h70]}, 32'h4433_2211);

      // Address wrap at the top of the space.
      wq.delete();
      lsb_req(1'b1, 32'hFFFF_FFFF, SH, 32'h0000_5AA5, 3'd0);
      repeat (4) step();
      chk("wrap_cnt", wq.size(), 32'd2);
      if (wq.size() == 2) begin
         chk("wrap_a0", wq[0][39:8], 32'hFFFF_FFFF);
         chk("wrap_d0", {24'b0, wq[0][7:0]}, 32'hA5);
         chk("wrap_a1", wq[1][39:8], 32'h0);
         chk("wrap_d1", {24'b0, wq[1][7:0]}, 32'h5A);
      end

      // IO store with the UART buffer full.
      wq.delete();
      io_buffer_full = 1'b1;
      lsb_req(1'b1, 32'h3_0000, SB, 32'h77, 3'd0);
`ifdef IO_BUFFER_STALL_EN
      repeat (3) begin
         step();
         chk("io_stall_wr", {31'b0, mem_wr}, 32'd0);
         chk("io_stall_a", mem_a, 32'h3_0000);
      end
      step();
      io_buffer_full = 1'b0;
      #1;
      chk("io_go", {23'b0, mem_wr, mem_dout}, 32'h177);
      step();
`else
      step();
      chk("io_nostall", {23'b0, mem_wr, mem_dout}, 32'h177);
      chk("io_a", mem_a, 32'h3_0000);
      step();
      io_buffer_full = 1'b0;
`endif
      chk("io_end", {30'b0, mem_wr, mem_busy}, 32'd0);
      chk("io_cnt", wq.size(), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
